// File: rtl/colour_map_stream.sv
// Iteration-count to RGB mapper: normalise against frame max_iter, add the
// colour-cycling offset, apply a palette, and present registered RGB + markers.
module colour_map_stream #(
  parameter int                      MAX_ITER_WIDTH = 16,
  parameter int                      COLOUR_WIDTH   = 8,
  parameter logic [COLOUR_WIDTH-1:0] INV_KNEE       = 8'h3C
) (
  input  logic                      clk_i,
  input  logic                      rst_i,
  input  logic                      valid_i,
  output logic                      ready_o,
  input  logic [MAX_ITER_WIDTH-1:0] iter_i,
  input  logic                      sof_i,
  input  logic                      eol_i,
  input  logic [MAX_ITER_WIDTH-1:0] max_iter_i,
  input  logic [1:0]                palette_i,
  input  logic                      cycle_en_i,
  input  logic [COLOUR_WIDTH-1:0]   cycle_step_i,
  output logic                      valid_o,
  input  logic                      ready_i,
  output logic [COLOUR_WIDTH-1:0]   r_o,
  output logic [COLOUR_WIDTH-1:0]   g_o,
  output logic [COLOUR_WIDTH-1:0]   b_o,
  output logic                      sof_o,
  output logic                      eol_o
);
  localparam int MW = MAX_ITER_WIDTH;
  localparam int C  = COLOUR_WIDTH;

  typedef struct packed {
    logic         sof;
    logic         eol;
    logic [C-1:0] r;
    logic [C-1:0] g;
    logic [C-1:0] b;
  } pix_t;

  logic [3:1] vld_pipe;
  logic       adv1, adv2, adv3, in_fire;

  assign adv3    = !vld_pipe[3] || ready_i;
  assign adv2    = !vld_pipe[2] || adv3;
  assign adv1    = !vld_pipe[1] || adv2;
  assign ready_o = adv1;
  assign in_fire = valid_i && ready_o;
  assign valid_o = vld_pipe[3];

  // Frame configuration, latched on each accepted sof beat
  logic [MW-1:0] max_q;
  logic [1:0]    pal_q;
  logic [C-1:0]  acc_q, off_q;

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      max_q <= '0;
      pal_q <= '0;
      acc_q <= '0;
      off_q <= '0;
    end else if (in_fire && sof_i) begin
      max_q <= max_iter_i;
      pal_q <= palette_i;
      off_q <= acc_q;
      acc_q <= acc_q + (cycle_en_i ? cycle_step_i : '0);
    end
  end

  // The sof beat itself must see its own frame's config, so bypass the latches
  logic [MW-1:0]   eff_max;
  logic [1:0]      eff_pal;
  logic [C-1:0]    eff_off;
  logic [MW+C-1:0] wide_iter, s_wide;
  logic [C-1:0]    v_in;
  logic            black_in;
  int              p;

  always_comb begin
    eff_max   = sof_i ? max_iter_i : max_q;
    eff_pal   = sof_i ? palette_i  : pal_q;
    eff_off   = sof_i ? acc_q      : off_q;
    p         = 0;
    for (int i = 0; i < MW; i++)
      if (eff_max[i]) p = i;
    wide_iter = {{C{1'b0}}, iter_i};
    if (p >= C - 1) s_wide = wide_iter >> (p - (C - 1));
    else            s_wide = wide_iter << ((C - 1) - p);
    v_in      = s_wide[C-1:0] + eff_off;
    black_in  = (eff_max == '0) || (iter_i >= eff_max);
  end

  // S1: normalised value plus the per-beat config it needs downstream
  logic [C-1:0] s1_v;
  logic         s1_black, s1_sof, s1_eol;
  logic [1:0]   s1_pal;

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      s1_v     <= '0;
      s1_black <= 1'b0;
      s1_sof   <= 1'b0;
      s1_eol   <= 1'b0;
      s1_pal   <= '0;
    end else if (in_fire) begin
      s1_v     <= v_in;
      s1_black <= black_in;
      s1_sof   <= sof_i;
      s1_eol   <= eol_i;
      s1_pal   <= eff_pal;
    end
  end

  // S2 palette lookup
  logic [C-1:0] inv;
  pix_t         pal_pix, s2_pix, s3_pix;

  always_comb begin
    inv         = (s1_v <= INV_KNEE) ? INV_KNEE - s1_v : '0;
    pal_pix     = '0;
    pal_pix.sof = s1_sof;
    pal_pix.eol = s1_eol;
    if (!s1_black) begin
      unique case (s1_pal)
        2'd0:    begin pal_pix.r = s1_v; pal_pix.g = s1_v; pal_pix.b = inv;  end
        2'd1:    begin pal_pix.r = s1_v; pal_pix.g = inv;  pal_pix.b = s1_v; end
        2'd2:    begin pal_pix.r = inv;  pal_pix.g = s1_v; pal_pix.b = s1_v; end
        default: begin pal_pix.r = s1_v; pal_pix.g = s1_v; pal_pix.b = s1_v; end
      endcase
    end
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      s2_pix <= '0;
      s3_pix <= '0;
    end else begin
      if (adv2 && vld_pipe[1]) s2_pix <= pal_pix;
      if (adv3 && vld_pipe[2]) s3_pix <= s2_pix;
    end
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      vld_pipe <= '0;
    end else begin
      if (adv1) vld_pipe[1] <= in_fire;
      if (adv2) vld_pipe[2] <= vld_pipe[1];
      if (adv3) vld_pipe[3] <= vld_pipe[2];
    end
  end

  assign r_o   = s3_pix.r;
  assign g_o   = s3_pix.g;
  assign b_o   = s3_pix.b;
  assign sof_o = s3_pix.sof;
  assign eol_o = s3_pix.eol;

endmodule

// File: doc/colour_map_stream.md
Name: colour_map_stream

Overview:
- Pipelined, parametrised iteration-to-RGB mapper for the fractal pixel stream.
- Sits between the escape-time compute cores and the video/DMA packer.
- Accepts one iteration count per beat over a valid/ready handshake.
- Normalises each count against a per-frame max_iter, applies a selectable palette plus a per-frame colour-cycling offset, and emits registered RGB with frame/line markers.

Parameters:
- MAX_ITER_WIDTH, 16, width of iteration count and max_iter.
- COLOUR_WIDTH, 8, bits per colour channel (C).
- INV_KNEE, 8'h3C, knee constant K for inverted channels (COLOUR_WIDTH bits).

Ports:
- clk_i  in  1  clock
- rst_i  in  1  synchronous active-high reset
- valid_i  in  1  input beat valid
- ready_o  out  1  block can accept a beat
- iter_i  in  MAX_ITER_WIDTH  iteration count of pixel
- sof_i  in  1  first pixel of frame
- eol_i  in  1  last pixel of line
- max_iter_i  in  MAX_ITER_WIDTH  frame max_iter, sampled on accepted sof beat
- palette_i  in  2  palette select, sampled on accepted sof beat
- cycle_en_i  in  1  enable offset advance, sampled on accepted sof beat
- cycle_step_i  in  COLOUR_WIDTH  offset increment per frame
- valid_o  out  1  output beat valid
- ready_i  in  1  downstream accepts
- r_o, g_o, b_o  out  COLOUR_WIDTH each  colour channels
- sof_o, eol_o  out  1 each  markers aligned with RGB

Behaviour:
- Clock and reset: one clock, clk_i. Reset rst_i is synchronous and active-high.
- Reset state:
  - All stage valids = 0; valid_o = 0.
  - r/g/b/sof/eol outputs = 0.
  - Latched max_iter = 0, palette = 0.
  - Offset accumulator and frame offset = 0.
  - Reset mid-frame discards all in-flight beats. No output beat appears for them.
- Handshake:
  - A beat is accepted when valid_i && ready_o. An output beat is transferred when valid_o && ready_i.
  - 3-stage pipeline (S1 normalise, S2 palette, S3 output register). Latency is 3 cycles from acceptance to valid_o when unstalled; throughput is 1 beat/cycle.
  - Each stage advances when it is empty or the next stage advances. ready_o = !S1.valid || S1 advances (combinational path from ready_i permitted).
  - While valid_o && !ready_i, all outputs hold stable.
  - Beats are never dropped, duplicated or reordered.
- Frame config:
  - On an accepted beat with sof_i=1, latch max_iter_i and palette_i. This beat and all later beats until the next sof use the latched values.
  - On the same accepted sof beat: frame_offset <= accumulator; accumulator <= accumulator + (cycle_en_i ? cycle_step_i : 0), mod 2^C. So frame n (counted from reset) uses offset n*step.
  - Beats before the first sof after reset use max_iter=0, which gives black.
- Normalise (S1):
  - p = index of the most significant set bit of max_iter.
  - If p >= C-1: s = iter >> (p-(C-1)). Otherwise s = iter << (C-1-p).
  - Keep the low C bits of s (wide intermediate, truncate).
  - Then v = (s + frame_offset) mod 2^C.
- Black rule: max_iter == 0 or iter >= max_iter gives r=g=b=0. Offset and palette are ignored for these pixels.
- Palette (S2), with inv = (v <= K) ? K - v : 0:
  - 0: r=v, g=v, b=inv.
  - 1: r=v, g=inv, b=v.
  - 2: r=inv, g=v, b=v.
  - 3: r=g=b=v (greyscale).
- Markers: sof_o and eol_o travel with their beat through all stages.
- Simultaneous events: a sof beat accepted while earlier-frame beats are still in flight does not alter those beats. Config is carried per stage with each beat or is sampled only at S1 entry.

Test Plan:
- Basic mapping: sof, max_iter=1000, palette 0, cycle off; iter=100 -> s=0x19, r=g=0x19, b=0x23, valid_o 3 cycles after accept.
- Left shift and greyscale: sof, max_iter=50, palette 3; iter=10 -> r=g=b=0x28. iter=50 and iter=60 -> 0,0,0.
- Cycling and wrap: max_iter=256, palette 0, cycle_en=1, step=0x10, iter=200 each frame.
  - Frame 0 -> r=g=0x64, b=0.
  - Frame 1 -> r=g=0x74.
  - Frame 16 -> back to 0x64.
- Backpressure: stream 8 back-to-back beats (iter 0..7, max_iter=128), hold ready_i=0 for cycles 4-9.
  - ready_o falls once the pipeline is full.
  - Outputs stay stable throughout.
  - All 8 beats are emitted in order with correct eol_o/sof_o.
- Reset mid-frame: assert rst_i for 1 cycle with 3 beats in flight.
  - valid_o=0 next cycle; no stale beat emerges.
  - Next frame after reset uses offset 0.
- Boundaries:
  - max_iter=0 -> black for any iter.
  - max_iter=1, iter=0 -> s=0, palette 1 gives r=0, g=0x3C, b=0.
  - max_iter=0xFFFF, iter=0xFFFE -> s=0xFF, palette 2 gives r=0, g=b=0xFF.
